// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment digit scanner with double-buffered frame commit.
// Define SEG_LZ_SUPPRESS_EN to blank leading zero digits.
module seven_seg_scanner #(
  parameter int         NUM_DIGITS = 8,
  parameter int         PRESCALE   = 50000,
  parameter logic [3:0] BLANK_CODE = 4'hA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    update,
  output logic [3:0]              data_out,
  output logic [NUM_DIGITS-1:0]   display_column,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] CMAX = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    GAP
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_idx;
  logic [CW-1:0]           r_cnt;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] r_shd_dig;
  logic [4*NUM_DIGITS-1:0] r_act_dig;
  logic [NUM_DIGITS-1:0]   r_shd_mask;
  logic [NUM_DIGITS-1:0]   r_act_mask;

  logic                    w_tick;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic [3:0]              w_code;

  assign w_tick   = (r_state != GAP) && (r_cnt == CMAX);
  assign w_commit = (r_state == GAP) && (r_idx == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_shd_dig  <= '0;
      r_act_dig  <= '0;
      r_shd_mask <= '1;
      r_act_mask <= '1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= SCAN;
            r_idx   <= '0;
          end
        end
        SCAN: begin
          if (w_tick) r_state <= GAP;
        end
        GAP: begin
          r_state <= SCAN;
          r_idx   <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
        end
        default: r_state <= IDLE;
      endcase

      if (r_state == GAP || w_tick) r_cnt <= '0;
      else                          r_cnt <= r_cnt + 1'b1;

      // Commit reads the pre-edge shadow; a same-edge capture stays pending.
      if (w_commit && r_pending) begin
        r_act_dig  <= r_shd_dig;
        r_act_mask <= r_shd_mask;
        r_pending  <= 1'b0;
      end
      if (update) begin
        r_shd_dig  <= digits_in;
        r_shd_mask <= blank_mask;
        r_pending  <= 1'b1;
      end
    end
  end

`ifdef SEG_LZ_SUPPRESS_EN
  logic                  w_run;
  logic [NUM_DIGITS-1:0] w_lz;

  // Walk down from the top digit; a nonzero or masked digit ends the run.
  always_comb begin
    w_run = 1'b1;
    w_lz  = '0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      w_run   = w_run & (r_act_dig[4*k +: 4] == 4'h0) & ~r_act_mask[k];
      w_lz[k] = w_run;
    end
  end

  assign w_blank = r_act_mask | w_lz;
`else
  assign w_blank = r_act_mask;
`endif

  assign w_code = w_blank[r_idx] ? BLANK_CODE
                                 : r_act_dig[{r_idx, 2'b00} +: 4];

  always_comb begin
    display_column = '1;
    data_out       = BLANK_CODE;
    if (r_state == SCAN) begin
      display_column[r_idx] = 1'b0;
      data_out              = w_code;
    end
  end

  assign frame_done = w_commit;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (4 digits, prescale 4, blank 4'hA).
// Expected frames follow the SEG_LZ_SUPPRESS_EN setting of the build.
module tb_seven_seg_scanner;

  localparam int         ND = 4;
  localparam int         PS = 4;
  localparam logic [3:0] BC = 4'hA;

`ifdef SEG_LZ_SUPPRESS_EN
  localparam logic [15:0] EXP_0705 = 16'hA705;
  localparam logic [15:0] EXP_0050 = 16'hAA50;
  localparam logic [15:0] EXP_MSK  = 16'hAAA0;
`else
  localparam logic [15:0] EXP_0705 = 16'h0705;
  localparam logic [15:0] EXP_0050 = 16'h0050;
  localparam logic [15:0] EXP_MSK  = 16'h00A0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  blank_mask = '0;
  logic        update = 1'b0;
  logic [3:0]  data_out;
  logic [3:0]  display_column;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS(ND),
    .PRESCALE  (PS),
    .BLANK_CODE(BC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .digits_in     (digits_in),
    .blank_mask    (blank_mask),
    .update        (update),
    .data_out      (data_out),
    .display_column(display_column),
    .frame_done    (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic blank_cycle(input string tag, input logic fd);
    chk({tag, " col"}, 32'(display_column), 32'hF);
    chk({tag, " data"}, 32'(data_out), 32'(BC));
    chk({tag, " fdone"}, 32'(frame_done), 32'(fd));
  endtask

  task automatic apply(input int k,
                       input int u1, input logic [15:0] d1,
                       input logic [3:0] m1,
                       input int u2, input logic [15:0] d2,
                       input logic [3:0] m2);
    update = 1'b0;
    if (k == u1) begin
      update = 1'b1; digits_in = d1; blank_mask = m1;
    end
    if (k == u2) begin
      update = 1'b1; digits_in = d2; blank_mask = m2;
    end
  endtask

  task automatic run_idle(input string tag);
    for (int i = 0; i < 4; i++) begin
      blank_cycle(tag, 1'b0);
      step();
    end
  endtask

  // Starts at the first lit clock of digit 0; ends at the next frame start.
  task automatic run_frame(input string tag, input logic [15:0] exp,
                           input int u1, input logic [15:0] d1,
                           input logic [3:0] m1,
                           input int u2, input logic [15:0] d2,
                           input logic [3:0] m2);
    int         k;
    logic [3:0] one;
    logic [3:0] col;
    k   = 0;
    one = 4'b0001;
    for (int d = 0; d < 4; d++) begin
      col = ~(one << d);
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("%s d%0d c%0d col", tag, d, c),
            32'(display_column), 32'(col));
        chk($sformatf("%s d%0d c%0d data", tag, d, c),
            32'(data_out), 32'(exp[4*d +: 4]));
        chk($sformatf("%s d%0d c%0d fdone", tag, d, c),
            32'(frame_done), 32'h0);
        apply(k, u1, d1, m1, u2, d2, m2);
        step();
        k++;
      end
      blank_cycle($sformatf("%s gap%0d", tag, d), d == 3);
      apply(k, u1, d1, m1, u2, d2, m2);
      step();
      k++;
    end
    update = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    blank_cycle("in_reset", 1'b0);
    reset = 1'b0;

    run_idle("idle");
    run_frame("f1_blank", 16'hAAAA, -1, '0, '0, -1, '0, '0);
    run_frame("f2_upd_mid", 16'hAAAA, 7, 16'h4321, 4'h0, -1, '0, '0);
    run_frame("f3_4321", 16'h4321, 5, 16'h1111, 4'h0,
              19, 16'h0705, 4'h0);
    run_frame("f4_1111", 16'h1111, -1, '0, '0, -1, '0, '0);
    run_frame("f5_0705", EXP_0705, 3, 16'h0050, 4'h0, -1, '0, '0);
    run_frame("f6_0050", EXP_0050, 0, 16'h0000, 4'b0010, -1, '0, '0);
    run_frame("f7_mask", EXP_MSK, -1, '0, '0, -1, '0, '0);

    chk("f8 d0 col", 32'(display_column), 32'hE);
    step();
    step();
    update = 1'b1; digits_in = 16'h9999; blank_mask = 4'h0;
    step();
    update = 1'b0;
    repeat (7) step();
    chk("f8 d2 col", 32'(display_column), 32'hB);
    chk("f8 d2 data", 32'(data_out), 32'(EXP_MSK[11:8]));
    step();

    reset = 1'b1;
    #1;
    blank_cycle("mid_reset", 1'b0);
    repeat (2) @(posedge clk);
    #1;
    blank_cycle("held_reset", 1'b0);
    reset = 1'b0;

    run_idle("idle2");
    run_frame("r1_blank", 16'hAAAA, -1, '0, '0, -1, '0, '0);
    run_frame("r2_blank", 16'hAAAA, -1, '0, '0, -1, '0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 8, giving the number of multiplexed digits (legal range 2..16).
REQ-002 The block SHALL have parameter PRESCALE, default 50000, giving the clocks each digit stays lit (legal range 2..65535).
REQ-003 The block SHALL have parameter BLANK_CODE, default 4'hA, giving the 4-bit code the decoder renders as an unlit digit.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port digits_in, input, 4*NUM_DIGITS bits: digit codes, digit 0 at [3:0], digit k at [4k+3:4k].
REQ-007 The block SHALL have port blank_mask, input, NUM_DIGITS bits: bit k=1 forces digit k to BLANK_CODE.
REQ-008 The block SHALL have port update, input, 1 bit: single-cycle strobe that captures digits_in and blank_mask.
REQ-009 The block SHALL have port data_out, output, 4 bits: code for the currently enabled digit.
REQ-010 The block SHALL have port display_column, output, NUM_DIGITS bits: active-low digit enables, at most one bit low.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-012 The block SHALL implement states IDLE, SCAN and GAP plus a digit index idx (0..NUM_DIGITS-1).
REQ-013 The block SHALL run prescaler cnt 0..PRESCALE-1 in IDLE and SCAN, clear it in GAP, and raise tick when cnt==PRESCALE-1.
REQ-014 In IDLE the block SHALL drive display_column all ones and data_out BLANK_CODE, and on tick go to SCAN with idx=0.
REQ-015 In SCAN the block SHALL drive display_column bit idx low (others high) and data_out the active code of digit idx; on tick it SHALL go to GAP.
REQ-016 GAP SHALL last exactly one clock with display_column all ones and data_out BLANK_CODE (anti-ghosting), then go to SCAN with idx+1, wrapping NUM_DIGITS-1 to 0.
REQ-017 Each digit SHALL be lit exactly PRESCALE clocks; a full frame SHALL be NUM_DIGITS*(PRESCALE+1) clocks.
REQ-018 On update=1 the block SHALL load digits_in and blank_mask into shadow registers and set a pending flag; a later update before commit SHALL overwrite the shadow.
REQ-019 In the GAP that follows idx=NUM_DIGITS-1 the block SHALL pulse frame_done and, if pending, copy shadow to active registers and clear pending.
REQ-020 If update coincides with a commit cycle, the commit SHALL use the shadow value held before that edge, and the new capture SHALL remain pending for the next frame.
REQ-021 Active registers SHALL change only at commit, so no frame ever mixes old and new digit values.
REQ-022 The displayed code for digit k SHALL be BLANK_CODE when active blank_mask[k]=1, else active digit k.
REQ-023 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.

Reset
REQ-024 Asserting reset at any time, including mid-frame, SHALL immediately force state IDLE, idx=0, cnt=0, pending=0, shadow/active digits=0, and shadow/active blank_mask all ones.
REQ-025 During reset the outputs SHALL be display_column all ones, data_out=BLANK_CODE and frame_done=0.

Configuration
REQ-026 With macro SEG_LZ_SUPPRESS_EN defined, the block SHALL display as BLANK_CODE every digit from index NUM_DIGITS-1 downward whose active code is 0 until the first nonzero or masked digit; digit 0 is never suppressed.
REQ-027 With SEG_LZ_SUPPRESS_EN undefined, the block SHALL display zero digits as 0 and SHALL contain no suppression logic.

Verification (NUM_DIGITS=4, PRESCALE=4, BLANK_CODE=4'hA)
REQ-028 Scenario: release reset, no update -> IDLE for 4 clocks, then columns 1110,1101,1011,0111, each low 4 clocks separated by one all-ones clock; data_out=A throughout; frame_done once per 20 clocks.
REQ-029 Scenario: update with digits_in=16'h4321, blank_mask=0000 mid-frame -> values unchanged until the next frame_done, then digit k shows k+1, never mixed within a frame.
REQ-030 Scenario: update with 16'h0705 on the same cycle as frame_done, after an earlier pending 16'h1111 -> next frame shows 1111 and the following frame shows 0705.
REQ-031 Scenario: digits 16'h0050 committed -> with SEG_LZ_SUPPRESS_EN: A,A,5,0 for digits 3..0; without it: 0,0,5,0.
REQ-032 Scenario: assert reset during SCAN idx=2 -> display_column=1111 and data_out=A in the same cycle; after release the block restarts from IDLE with all digits blanked.
